rc4_key_search_scheduler: RTL and testbench

- Top-level sequencer for the RC4 key-search datapath.
- For each candidate key it runs three engines in order, each once: S-box init (S[i]=i), key schedule (KSA), then the PRGA decryptor.
- It time-shares the single S RAM port between the three engines and checks each decrypted byte for plaintext validity.
- It stops when a key yields valid plaintext or the key space is exhausted.
- Sits between the board I/O (go/status/key display) and the three engines.

---
 rtl/rc4_pkg.sv | 29 ++
 rtl/rc4_plaintext_checker.sv | 42 ++++
 rtl/rc4_key_search_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_rc4_key_search_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search scheduler.
package rc4_pkg;

  // Sequencer states; the encoding doubles as the debug phase value.
  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_INIT_START = 4'd1,
    ST_INIT_WAIT  = 4'd2,
    ST_KSA_START  = 4'd3,
    ST_KSA_WAIT   = 4'd4,
    ST_DEC_START  = 4'd5,
    ST_DEC_WAIT   = 4'd6,
    ST_CHECK      = 4'd7,
    ST_FOUND      = 4'd8,
    ST_FAIL       = 4'd9
  } state_e;

  localparam int PHASE_W = 4;

  // Printable plaintext: lowercase letters and space.
  localparam logic [7:0] CHAR_A     = 8'h61;
  localparam logic [7:0] CHAR_Z     = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  function automatic logic [PHASE_W-1:0] phase_of(input state_e s);
    return PHASE_W'(s);
  endfunction

endpackage

// File: rtl/rc4_plaintext_checker.sv
// Sticky flag raised when the decryptor emits a byte that is not
// lowercase ASCII or space.
module rc4_plaintext_checker
  import rc4_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic              strobe,
  input  logic [DATA_W-1:0] data,
  output logic              bad
);

  logic bad_q, bad_d;

  function automatic logic is_plain(input logic [DATA_W-1:0] b);
    return ((b >= DATA_W'(CHAR_A)) && (b <= DATA_W'(CHAR_Z))) ||
           (b == DATA_W'(CHAR_SPACE));
  endfunction

  // Clear has priority; otherwise latch any invalid byte seen while enabled.
  always_comb begin
    bad_d = bad_q;
    if (clear) begin
      bad_d = 1'b0;
    end else if (enable && strobe && !is_plain(data)) begin
      bad_d = 1'b1;
    end
  end

  // Flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bad_q <= 1'b0;
    else       bad_q <= bad_d;
  end

  assign bad = bad_q;

endmodule

// File: rtl/rc4_key_search_scheduler.sv
// Top-level RC4 key-search sequencer: walks candidate keys through the
// init / KSA / decrypt engines, arbitrates the S RAM port and stops on
// valid plaintext, key-space exhaustion or an engine watchdog expiry.
module rc4_key_search_scheduler
  import rc4_pkg::*;
#(
  parameter int                   RAM_WIDTH      = 8,
  parameter int                   RAM_LENGTH     = 8,
  parameter int                   KEY_WIDTH      = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_MAX        = 24'h3FFFFF,
  parameter int                   TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  output logic                  init_start,
  output logic                  ksa_start,
  output logic                  dec_start,
  input  logic                  init_done,
  input  logic                  ksa_done,
  input  logic                  dec_done,
  input  logic [RAM_LENGTH-1:0] init_addr,
  input  logic [RAM_LENGTH-1:0] ksa_addr,
  input  logic [RAM_LENGTH-1:0] dec_addr,
  input  logic [RAM_WIDTH-1:0]  init_din,
  input  logic [RAM_WIDTH-1:0]  ksa_din,
  input  logic [RAM_WIDTH-1:0]  dec_din,
  input  logic                  init_wren,
  input  logic                  ksa_wren,
  input  logic                  dec_wren,
  output logic [RAM_LENGTH-1:0] s_addr,
  output logic [RAM_WIDTH-1:0]  s_din,
  output logic                  s_wren,
  input  logic                  dec_a_wren,
  input  logic [RAM_WIDTH-1:0]  dec_a_data,
  output logic [KEY_WIDTH-1:0]  key,
  output logic                  busy,
  output logic                  found,
  output logic                  failed,
  output logic                  timeout,
  output logic [PHASE_W-1:0]    phase
);

  localparam int                WDOG_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q, key_d;
  logic [WDOG_W-1:0]    wdog_q, wdog_d;
  logic                 timeout_q, timeout_d;
  logic                 go_q;
  logic                 go_rise;
  logic                 in_wait;
  logic                 wdog_exp;
  logic                 bad;
  logic                 clear_bad;

  assign go_rise  = go & ~go_q;
  assign in_wait  = (state_q == ST_INIT_WAIT) || (state_q == ST_KSA_WAIT) ||
                    (state_q == ST_DEC_WAIT);
  assign wdog_exp = (wdog_q == WDOG_LAST);

  // Every new candidate starts with a clean plaintext verdict.
  assign clear_bad = (state_d == ST_INIT_START) && (state_q != ST_INIT_START);

  rc4_plaintext_checker #(
    .DATA_W (RAM_WIDTH)
  ) u_checker (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_bad),
    .enable (state_q == ST_DEC_WAIT),
    .strobe (dec_a_wren),
    .data   (dec_a_data),
    .bad    (bad)
  );

  // Next-state, key and timeout-flag logic; a done pulse beats the watchdog.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    timeout_d = timeout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go_rise) begin
          state_d   = ST_INIT_START;
          key_d     = '0;
          timeout_d = 1'b0;
        end
      end
      ST_INIT_START: state_d = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (init_done) begin
          state_d = ST_KSA_START;
        end else if (wdog_exp) begin
          state_d   = ST_FAIL;
          timeout_d = 1'b1;
        end
      end
      ST_KSA_START: state_d = ST_KSA_WAIT;
      ST_KSA_WAIT: begin
        if (ksa_done) begin
          state_d = ST_DEC_START;
        end else if (wdog_exp) begin
          state_d   = ST_FAIL;
          timeout_d = 1'b1;
        end
      end
      ST_DEC_START: state_d = ST_DEC_WAIT;
      ST_DEC_WAIT: begin
        if (dec_done) begin
          state_d = ST_CHECK;
        end else if (wdog_exp) begin
          state_d   = ST_FAIL;
          timeout_d = 1'b1;
        end
      end
      ST_CHECK: begin
        if (!bad) begin
          state_d = ST_FOUND;
        end else if (key_q == KEY_MAX) begin
          state_d = ST_FAIL;
        end else begin
          key_d   = key_q + KEY_WIDTH'(1);
          state_d = ST_INIT_START;
        end
      end
      ST_FOUND, ST_FAIL: begin
        if (go_rise) begin
          state_d = ST_INIT_START;
          key_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Watchdog restarts on any state change and only counts while waiting.
  always_comb begin
    wdog_d = '0;
    if (in_wait && (state_d == state_q)) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      key_q     <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
      go_q      <= go;
    end
  end

  // S RAM grant follows the engine owning the current state; START states
  // are included so an engine's first-cycle address reaches the RAM.
  always_comb begin
    s_addr = '0;
    s_din  = '0;
    s_wren = 1'b0;
    unique case (state_q)
      ST_INIT_START, ST_INIT_WAIT: begin
        s_addr = init_addr;
        s_din  = init_din;
        s_wren = init_wren;
      end
      ST_KSA_START, ST_KSA_WAIT: begin
        s_addr = ksa_addr;
        s_din  = ksa_din;
        s_wren = ksa_wren;
      end
      ST_DEC_START, ST_DEC_WAIT: begin
        s_addr = dec_addr;
        s_din  = dec_din;
        s_wren = dec_wren;
      end
      default: ;
    endcase
  end

  assign init_start = (state_q == ST_INIT_START);
  assign ksa_start  = (state_q == ST_KSA_START);
  assign dec_start  = (state_q == ST_DEC_START);
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_FOUND) &&
                      (state_q != ST_FAIL);
  assign found      = (state_q == ST_FOUND);
  assign failed     = (state_q == ST_FAIL);
  assign key        = key_q;
  assign timeout    = timeout_q;
  assign phase      = phase_of(state_q);

endmodule

// File: tb/tb_rc4_key_search_scheduler.sv
// Directed bench for rc4_key_search_scheduler with behavioural engine models.
module tb_rc4_key_search_scheduler;

  localparam int RW = 8;
  localparam int RL = 8;
  localparam int KW = 24;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic          init_start, ksa_start, dec_start;
  logic          init_done, ksa_done, dec_done_m, stray;
  logic          dec_done;
  logic [RL-1:0] init_addr, ksa_addr, dec_addr;
  logic [RW-1:0] init_din, ksa_din, dec_din;
  logic          init_wren, ksa_wren, dec_wren;
  logic [RL-1:0] s_addr;
  logic [RW-1:0] s_din;
  logic          s_wren;
  logic          dec_a_wren;
  logic [RW-1:0] dec_a_data;
  logic [KW-1:0] key;
  logic          busy, found, failed, timeout;
  logic [3:0]    phase;

  assign dec_done = dec_done_m | stray;

  int n_checks = 0;
  int n_fail   = 0;
  int scen     = 0;
  logic ksa_en    = 1'b1;
  logic grant_chk = 1'b0;
  logic stray_en  = 1'b0;

  int cyc = 0, n_init = 0, n_ksa = 0, n_dec = 0;
  int c_init = 0, c_ksa = 0, c_dec = 0;

  rc4_key_search_scheduler #(
    .RAM_WIDTH      (RW),
    .RAM_LENGTH     (RL),
    .KEY_WIDTH      (KW),
    .KEY_MAX        (24'd3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .init_start (init_start),
    .ksa_start  (ksa_start),
    .dec_start  (dec_start),
    .init_done  (init_done),
    .ksa_done   (ksa_done),
    .dec_done   (dec_done),
    .init_addr  (init_addr),
    .ksa_addr   (ksa_addr),
    .dec_addr   (dec_addr),
    .init_din   (init_din),
    .ksa_din    (ksa_din),
    .dec_din    (dec_din),
    .init_wren  (init_wren),
    .ksa_wren   (ksa_wren),
    .dec_wren   (dec_wren),
    .s_addr     (s_addr),
    .s_din      (s_din),
    .s_wren     (s_wren),
    .dec_a_wren (dec_a_wren),
    .dec_a_data (dec_a_data),
    .key        (key),
    .busy       (busy),
    .found      (found),
    .failed     (failed),
    .timeout    (timeout),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start-pulse monitor: counts high cycles and remembers when each was seen.
  always @(negedge clk) begin
    cyc++;
    if (init_start) begin n_init++; c_init = cyc; end
    if (ksa_start)  begin n_ksa++;  c_ksa  = cyc; end
    if (dec_start)  begin n_dec++;  c_dec  = cyc; end
  end

  // Init engine model: done 5 cycles after start; optional stray dec_done.
  initial begin
    init_done = 1'b0;
    stray     = 1'b0;
    forever begin
      @(negedge clk);
      if (init_start) begin
        if (grant_chk) begin
          check_eq("init_start_addr", s_addr, 8'h11);
          check_eq("init_start_din", s_din, 8'hA1);
          check_eq("init_start_wren", s_wren, 1);
        end
        @(negedge clk);
        if (grant_chk) check_eq("init_wait_addr", s_addr, 8'h11);
        if (stray_en) stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        if (stray_en) check_eq("stray_dec_done_ignored", phase, 2);
        repeat (2) @(negedge clk);
        init_done = 1'b1;
        @(negedge clk);
        init_done = 1'b0;
      end
    end
  end

  // KSA engine model: done 5 cycles after start unless disabled.
  initial begin
    ksa_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ksa_start) begin
        if (grant_chk) begin
          check_eq("ksa_start_addr", s_addr, 8'h22);
          check_eq("ksa_start_din", s_din, 8'hB2);
          check_eq("ksa_start_wren", s_wren, 0);
        end
        @(negedge clk);
        if (grant_chk) check_eq("ksa_wait_addr", s_addr, 8'h22);
        repeat (3) @(negedge clk);
        if (ksa_en) ksa_done = 1'b1;
        @(negedge clk);
        ksa_done = 1'b0;
      end
    end
  end

  // Decrypt engine model: emits a byte per cycle, last byte with done.
  initial begin
    logic [7:0] b [0:3];
    int nb;
    dec_done_m = 1'b0;
    dec_a_wren = 1'b0;
    dec_a_data = 8'h00;
    forever begin
      @(negedge clk);
      if (dec_start) begin
        if (grant_chk) begin
          check_eq("dec_start_addr", s_addr, 8'h33);
          check_eq("dec_start_din", s_din, 8'hC3);
        end
        nb = 1;
        b[0] = 8'h00; b[1] = 8'h00; b[2] = 8'h00; b[3] = 8'h00;
        case (scen)
          0: begin nb = 3; b[0] = 8'h68; b[1] = 8'h69; b[2] = 8'h20; end
          1: begin
            if (key == '0) begin nb = 1; b[0] = 8'h41; end
            else begin nb = 2; b[0] = 8'h61; b[1] = 8'h7A; end
          end
          default: begin nb = 1; b[0] = 8'h00; end
        endcase
        for (int j = 0; j < nb; j++) begin
          @(negedge clk);
          if (grant_chk && j == 0) begin
            check_eq("dec_wait_phase", phase, 6);
            check_eq("dec_wait_wren", s_wren, 1);
          end
          dec_a_wren = 1'b1;
          dec_a_data = b[j];
          if (j == nb - 1) dec_done_m = 1'b1;
        end
        @(negedge clk);
        dec_a_wren = 1'b0;
        dec_done_m = 1'b0;
        if (grant_chk) begin
          check_eq("check_phase", phase, 7);
          check_eq("check_swren", s_wren, 0);
          check_eq("check_saddr", s_addr, 0);
        end
      end
    end
  end

  task automatic wait_end(input string tag);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (found || failed) break;
    end
    check_eq(tag, found | failed, 1);
  endtask

  task automatic wait_ksa_start();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ksa_start) break;
    end
    check_eq("ksa_start_seen", ksa_start, 1);
  endtask

  initial begin
    int s_init, s_ksa, s_dec, n, k;
    init_addr = 8'h11; init_din = 8'hA1; init_wren = 1'b1;
    ksa_addr  = 8'h22; ksa_din  = 8'hB2; ksa_wren  = 1'b0;
    dec_addr  = 8'h33; dec_din  = 8'hC3; dec_wren  = 1'b1;
    reset = 1'b1;
    go    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_found", found, 0);
    check_eq("rst_failed", failed, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_key", key, 0);
    check_eq("rst_phase", phase, 0);
    check_eq("rst_swren", s_wren, 0);
    check_eq("rst_saddr", s_addr, 0);
    check_eq("rst_starts", {init_start, ksa_start, dec_start}, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_swren_gated", s_wren, 0);

    // Found at first key, with a stray dec_done and a mid-search go edge.
    s_init = n_init; s_ksa = n_ksa; s_dec = n_dec;
    scen = 0; grant_chk = 1'b1; stray_en = 1'b1;
    go = 1'b1;
    wait_ksa_start();
    go = 1'b0;
    @(negedge clk);
    go = 1'b1;
    wait_end("first_end");
    grant_chk = 1'b0; stray_en = 1'b0;
    check_eq("basic_init_pulses", n_init - s_init, 1);
    check_eq("basic_ksa_pulses", n_ksa - s_ksa, 1);
    check_eq("basic_dec_pulses", n_dec - s_dec, 1);
    check_eq("basic_order", (c_init < c_ksa) && (c_ksa < c_dec), 1);
    check_eq("first_found", found, 1);
    check_eq("first_key", key, 0);
    check_eq("first_busy", busy, 0);
    check_eq("first_failed", failed, 0);
    check_eq("first_phase", phase, 8);

    // Retry: key 0 gives 'A', key 1 gives lowercase.
    go = 1'b0;
    @(negedge clk);
    s_init = n_init; s_dec = n_dec;
    scen = 1;
    go = 1'b1;
    wait_end("retry_end");
    check_eq("retry_found", found, 1);
    check_eq("retry_key", key, 1);
    check_eq("retry_init_passes", n_init - s_init, 2);
    check_eq("retry_dec_passes", n_dec - s_dec, 2);

    // Exhaustion: every pass invalid, KEY_MAX = 3.
    go = 1'b0;
    @(negedge clk);
    s_dec = n_dec;
    scen = 2;
    go = 1'b1;
    wait_end("exhaust_end");
    check_eq("exhaust_failed", failed, 1);
    check_eq("exhaust_found", found, 0);
    check_eq("exhaust_key", key, 3);
    check_eq("exhaust_timeout", timeout, 0);
    check_eq("exhaust_passes", n_dec - s_dec, 4);

    // Watchdog: KSA never finishes.
    go = 1'b0;
    @(negedge clk);
    s_dec = n_dec;
    scen = 0; ksa_en = 1'b0;
    go = 1'b1;
    wait_ksa_start();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (failed) break;
    end
    check_eq("wdog_latency", n, 17);
    check_eq("wdog_failed", failed, 1);
    check_eq("wdog_timeout", timeout, 1);
    check_eq("wdog_phase", phase, 9);
    check_eq("wdog_no_dec", n_dec - s_dec, 0);
    ksa_en = 1'b1;

    // Asynchronous reset in DEC_WAIT of the second key.
    go = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check_eq("rst2_timeout", timeout, 0);
    check_eq("rst2_phase", phase, 0);
    reset = 1'b0;
    scen = 2;
    @(negedge clk);
    go = 1'b1;
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dec_start) begin
        k++;
        if (k == 2) break;
      end
    end
    check_eq("second_dec_start", k, 2);
    @(negedge clk);
    check_eq("pre_rst_swren", s_wren, 1);
    check_eq("pre_rst_key", key, 1);
    #1 reset = 1'b1;
    #1;
    check_eq("async_rst_swren", s_wren, 0);
    check_eq("async_rst_phase", phase, 0);
    check_eq("async_rst_key", key, 0);
    check_eq("async_rst_busy", busy, 0);
    repeat (10) @(negedge clk);
    go = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
